// File: rtl/wb_scoreboard_arb_if.sv
// Issue, write-back request and register-file write bundle for wb_scoreboard_arb.
// master = decode/execution side, slave = the scoreboard/arbiter.
interface wb_scoreboard_arb_if #(parameter int unsigned XLEN = 64);
   logic            iss_valid;
   logic [4:0]      iss_rs1;
   logic [4:0]      iss_rs2;
   logic [4:0]      iss_rd;
   logic            iss_wb;
   logic            iss_ready;
   logic            alu_valid;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            alu_ready;
   logic            lsu_valid;
   logic [4:0]      lsu_rd;
   logic [XLEN-1:0] lsu_data;
   logic            lsu_ready;
   logic            wb_en;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic [31:0]     busy;
   logic [31:0]     stall_cnt;
   logic            wb_err;

   modport master (
      output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wb,
      output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
      input  iss_ready, alu_ready, lsu_ready,
      input  wb_en, wb_rd, wb_data, busy, stall_cnt, wb_err
   );

   modport slave (
      input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wb,
      input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
      output iss_ready, alu_ready, lsu_ready,
      output wb_en, wb_rd, wb_data, busy, stall_cnt, wb_err
   );
endinterface

// File: rtl/wb_scoreboard_arb.sv
// Register scoreboard gating instruction issue, plus a round-robin ALU/LSU
// write-back arbiter driving a single register-file write port.
module wb_scoreboard_arb #(
   parameter int unsigned XLEN = 64
) (
   input logic                clk,
   input logic                rst,
   wb_scoreboard_arb_if.slave bus
);
   localparam int unsigned NREG = 32;
   localparam int unsigned RIDX = 5;

   typedef enum logic {
      GNT_ALU = 1'b0,
      GNT_LSU = 1'b1
   } gnt_e;

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic            wb_en_q;
   logic [RIDX-1:0] wb_rd_q;
   logic [XLEN-1:0] wb_data_q;
   logic [31:0]     stall_q;
   logic            err_q;
   gnt_e            last_q;

   logic hazard_c;
   logic fire_c;
   logic gnt_alu_c;
   logic gnt_lsu_c;

   // Hazard detection and round-robin grant, both combinational
   always_comb begin
      hazard_c  = bus.iss_valid &&
                  (((bus.iss_rs1 != '0) && busy_q[bus.iss_rs1]) ||
                   ((bus.iss_rs2 != '0) && busy_q[bus.iss_rs2]) ||
                   (bus.iss_wb && (bus.iss_rd != '0) && busy_q[bus.iss_rd]));
      fire_c    = bus.iss_valid && !hazard_c;
      gnt_alu_c = 1'b0;
      gnt_lsu_c = 1'b0;
      if (bus.alu_valid && bus.lsu_valid) begin
         gnt_alu_c = (last_q == GNT_LSU);
         gnt_lsu_c = (last_q == GNT_ALU);
      end else begin
         gnt_alu_c = bus.alu_valid;
         gnt_lsu_c = bus.lsu_valid;
      end
   end

   // Retiring write-back clears first so a same-edge issue set wins
   always_comb begin
      busy_d = busy_q;
      if (wb_en_q) begin
         busy_d[wb_rd_q] = 1'b0;
      end
      if (fire_c && bus.iss_wb && (bus.iss_rd != '0)) begin
         busy_d[bus.iss_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q    <= '0;
         wb_en_q   <= 1'b0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
         stall_q   <= '0;
         err_q     <= 1'b0;
         last_q    <= GNT_LSU;
      end else begin
         busy_q <= busy_d;
         if (gnt_alu_c) begin
            wb_en_q   <= (bus.alu_rd != '0);
            wb_rd_q   <= bus.alu_rd;
            wb_data_q <= bus.alu_data;
            last_q    <= GNT_ALU;
         end else if (gnt_lsu_c) begin
            wb_en_q   <= (bus.lsu_rd != '0);
            wb_rd_q   <= bus.lsu_rd;
            wb_data_q <= bus.lsu_data;
            last_q    <= GNT_LSU;
         end else begin
            wb_en_q <= 1'b0;
         end
         if (hazard_c && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
         end
         // A write-back to a register nobody is waiting on is a protocol error
         if (wb_en_q && !busy_q[wb_rd_q]) begin
            err_q <= 1'b1;
         end
      end
   end

   assign bus.iss_ready = !hazard_c;
   assign bus.alu_ready = gnt_alu_c;
   assign bus.lsu_ready = gnt_lsu_c;
   assign bus.wb_en     = wb_en_q;
   assign bus.wb_rd     = wb_rd_q;
   assign bus.wb_data   = wb_data_q;
   assign bus.busy      = busy_q;
   assign bus.stall_cnt = stall_q;
   assign bus.wb_err    = err_q;
endmodule

// File: tb/tb_wb_scoreboard_arb.sv
// Self-checking bench for wb_scoreboard_arb: directed scenarios plus a
// randomized run compared against a pending-register reference model.
module tb_wb_scoreboard_arb;
   localparam int unsigned XLEN = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_scoreboard_arb_if #(.XLEN(XLEN)) bus ();
   wb_scoreboard_arb #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: which registers await a result, what the write port shows
   bit              pend [32];
   bit              m_wb_en;
   logic [4:0]      m_wb_rd;
   logic [XLEN-1:0] m_wb_data;
   logic [31:0]     m_stall;
   bit              m_err;
   bit              m_last_alu;

   task automatic model_reset();
      foreach (pend[i]) pend[i] = 1'b0;
      m_wb_en = 0; m_wb_rd = '0; m_wb_data = '0; m_stall = '0; m_err = 0; m_last_alu = 0;
   endtask

   function automatic bit exp_iss_ready();
      bit blocked;
      blocked = ((bus.iss_rs1 != 0) && pend[bus.iss_rs1]) ||
                ((bus.iss_rs2 != 0) && pend[bus.iss_rs2]) ||
                (bus.iss_wb && (bus.iss_rd != 0) && pend[bus.iss_rd]);
      return !(bus.iss_valid && blocked);
   endfunction

   function automatic bit exp_alu_gnt();
      return bus.alu_valid && (!bus.lsu_valid || !m_last_alu);
   endfunction

   function automatic bit exp_lsu_gnt();
      return bus.lsu_valid && (!bus.alu_valid || m_last_alu);
   endfunction

   function automatic logic [31:0] exp_busy();
      logic [31:0] b;
      for (int i = 0; i < 32; i++) b[i] = pend[i];
      return b;
   endfunction

   task automatic idle_inputs();
      bus.iss_valid = 0; bus.iss_rs1 = '0; bus.iss_rs2 = '0; bus.iss_rd = '0; bus.iss_wb = 0;
      bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
      bus.lsu_valid = 0; bus.lsu_rd = '0; bus.lsu_data = '0;
   endtask

   task automatic set_issue(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input bit wb);
      bus.iss_valid = v; bus.iss_rs1 = rs1; bus.iss_rs2 = rs2; bus.iss_rd = rd; bus.iss_wb = wb;
   endtask

   // Advance the model by one clock using the inputs now applied, then clock the DUT
   task automatic tick();
      bit fire, stall, ga, gl;
      fire  = bus.iss_valid && exp_iss_ready();
      stall = bus.iss_valid && !exp_iss_ready();
      ga    = exp_alu_gnt();
      gl    = exp_lsu_gnt();
      if (m_wb_en) begin
         if (!pend[m_wb_rd]) m_err = 1;
         pend[m_wb_rd] = 0;
      end
      if (fire && bus.iss_wb && bus.iss_rd != 0) pend[bus.iss_rd] = 1;
      if (stall && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (ga) begin
         m_wb_en = (bus.alu_rd != 0); m_wb_rd = bus.alu_rd; m_wb_data = bus.alu_data; m_last_alu = 1;
      end else if (gl) begin
         m_wb_en = (bus.lsu_rd != 0); m_wb_rd = bus.lsu_rd; m_wb_data = bus.lsu_data; m_last_alu = 0;
      end else begin
         m_wb_en = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 0;
      idle_inputs();
      model_reset();
      @(negedge clk);
      rst = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 0;
      #2;
      n_checks++; if (bus.busy !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h expected 0", bus.busy); end
      n_checks++; if (bus.wb_en !== 1'b0) begin n_fail++; $display("FAIL reset_wb_en: got %b expected 0", bus.wb_en); end
      n_checks++; if (bus.wb_rd !== 5'd0) begin n_fail++; $display("FAIL reset_wb_rd: got %0d expected 0", bus.wb_rd); end
      n_checks++; if (bus.wb_data !== '0) begin n_fail++; $display("FAIL reset_wb_data: got %h expected 0", bus.wb_data); end
      n_checks++; if (bus.stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_stall: got %0d expected 0", bus.stall_cnt); end
      n_checks++; if (bus.wb_err !== 1'b0) begin n_fail++; $display("FAIL reset_wb_err: got %b expected 0", bus.wb_err); end
      n_checks++; if (bus.iss_ready !== 1'b1) begin n_fail++; $display("FAIL reset_iss_ready: got %b expected 1", bus.iss_ready); end
      do_reset();
   endtask

   task automatic test_raw_stall();
      set_issue(1, 5'd0, 5'd0, 5'd5, 1);
      #2;
      n_checks++; if (bus.iss_ready !== 1'b1) begin n_fail++; $display("FAIL raw_first_issue: got %b expected 1", bus.iss_ready); end
      tick();
      set_issue(1, 5'd5, 5'd0, 5'd6, 0);
      #2;
      n_checks++; if (bus.busy !== 32'h20) begin n_fail++; $display("FAIL raw_busy_set: got %h expected 00000020", bus.busy); end
      n_checks++; if (bus.iss_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall: got %b expected 0", bus.iss_ready); end
      tick();
      bus.alu_valid = 1; bus.alu_rd = 5'd5; bus.alu_data = 64'h1234;
      #2;
      n_checks++; if (bus.stall_cnt !== 32'd1) begin n_fail++; $display("FAIL raw_stall_cnt1: got %0d expected 1", bus.stall_cnt); end
      n_checks++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL raw_alu_grant: got %b expected 1", bus.alu_ready); end
      tick();
      bus.alu_valid = 0;
      #2;
      n_checks++; if (bus.wb_en !== 1'b1) begin n_fail++; $display("FAIL raw_wb_en: got %b expected 1", bus.wb_en); end
      n_checks++; if (bus.wb_rd !== 5'd5) begin n_fail++; $display("FAIL raw_wb_rd: got %0d expected 5", bus.wb_rd); end
      n_checks++; if (bus.wb_data !== 64'h1234) begin n_fail++; $display("FAIL raw_wb_data: got %h expected 1234", bus.wb_data); end
      n_checks++; if (bus.iss_ready !== 1'b0) begin n_fail++; $display("FAIL raw_still_stalled: got %b expected 0", bus.iss_ready); end
      tick();
      #2;
      n_checks++; if (bus.busy[5] !== 1'b0) begin n_fail++; $display("FAIL raw_busy_clear: got %b expected 0", bus.busy[5]); end
      n_checks++; if (bus.iss_ready !== 1'b1) begin n_fail++; $display("FAIL raw_released: got %b expected 1", bus.iss_ready); end
      n_checks++; if (bus.wb_en !== 1'b0) begin n_fail++; $display("FAIL raw_wb_en_drop: got %b expected 0", bus.wb_en); end
      n_checks++; if (bus.stall_cnt !== 32'd3) begin n_fail++; $display("FAIL raw_stall_cnt3: got %0d expected 3", bus.stall_cnt); end
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_tie();
      logic [XLEN-1:0] da, dl;
      do_reset();
      da = {$urandom, $urandom};
      dl = {$urandom, $urandom};
      set_issue(1, 5'd0, 5'd0, 5'd3, 1); tick();
      set_issue(1, 5'd0, 5'd0, 5'd4, 1); tick();
      idle_inputs();
      bus.alu_valid = 1; bus.alu_rd = 5'd3; bus.alu_data = da;
      bus.lsu_valid = 1; bus.lsu_rd = 5'd4; bus.lsu_data = dl;
      #2;
      n_checks++; if ({bus.alu_ready, bus.lsu_ready} !== 2'b10) begin n_fail++; $display("FAIL tie_first: got alu/lsu %b expected 10", {bus.alu_ready, bus.lsu_ready}); end
      tick();
      bus.alu_valid = 0;
      #2;
      n_checks++; if ({bus.wb_en, bus.wb_rd} !== {1'b1, 5'd3}) begin n_fail++; $display("FAIL tie_wb_alu: got en/rd %b/%0d expected 1/3", bus.wb_en, bus.wb_rd); end
      n_checks++; if (bus.wb_data !== da) begin n_fail++; $display("FAIL tie_data_alu: got %h expected %h", bus.wb_data, da); end
      n_checks++; if (bus.lsu_ready !== 1'b1) begin n_fail++; $display("FAIL tie_second: got %b expected 1", bus.lsu_ready); end
      tick();
      bus.lsu_valid = 0;
      #2;
      n_checks++; if ({bus.wb_en, bus.wb_rd} !== {1'b1, 5'd4}) begin n_fail++; $display("FAIL tie_wb_lsu: got en/rd %b/%0d expected 1/4", bus.wb_en, bus.wb_rd); end
      n_checks++; if (bus.wb_data !== dl) begin n_fail++; $display("FAIL tie_data_lsu: got %h expected %h", bus.wb_data, dl); end
      tick();
      #2;
      n_checks++; if (bus.wb_en !== 1'b0) begin n_fail++; $display("FAIL tie_wb_end: got %b expected 0", bus.wb_en); end
      n_checks++; if (bus.busy !== 32'h0) begin n_fail++; $display("FAIL tie_busy: got %h expected 0", bus.busy); end
      n_checks++; if (bus.wb_err !== 1'b0) begin n_fail++; $display("FAIL tie_err: got %b expected 0", bus.wb_err); end
   endtask

   task automatic test_rd0();
      set_issue(1, 5'd0, 5'd0, 5'd0, 1);
      bus.alu_valid = 1; bus.alu_rd = 5'd0; bus.alu_data = {$urandom, $urandom};
      #2;
      n_checks++; if (bus.iss_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_iss_ready: got %b expected 1", bus.iss_ready); end
      n_checks++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_alu_grant: got %b expected 1", bus.alu_ready); end
      tick();
      idle_inputs();
      #2;
      n_checks++; if (bus.busy !== 32'h0) begin n_fail++; $display("FAIL rd0_busy: got %h expected 0", bus.busy); end
      n_checks++; if (bus.wb_en !== 1'b0) begin n_fail++; $display("FAIL rd0_wb_en: got %b expected 0", bus.wb_en); end
      tick();
   endtask

   task automatic test_same_edge();
      set_issue(1, 5'd0, 5'd0, 5'd7, 1); tick();
      idle_inputs();
      bus.alu_valid = 1; bus.alu_rd = 5'd7; bus.alu_data = 64'hA5A5;
      #2;
      n_checks++; if (bus.busy !== 32'h80) begin n_fail++; $display("FAIL same_busy_set: got %h expected 00000080", bus.busy); end
      tick();
      bus.alu_valid = 0;
      set_issue(1, 5'd0, 5'd0, 5'd7, 1);
      #2;
      n_checks++; if ({bus.wb_en, bus.wb_rd} !== {1'b1, 5'd7}) begin n_fail++; $display("FAIL same_wb: got en/rd %b/%0d expected 1/7", bus.wb_en, bus.wb_rd); end
      n_checks++; if (bus.iss_ready !== exp_iss_ready()) begin n_fail++; $display("FAIL same_iss_ready: got %b expected %b", bus.iss_ready, exp_iss_ready()); end
      tick();
      #2;
      n_checks++; if (bus.iss_ready !== exp_iss_ready()) begin n_fail++; $display("FAIL same_iss_retry: got %b expected %b", bus.iss_ready, exp_iss_ready()); end
      tick();
      idle_inputs();
      #2;
      n_checks++; if (bus.busy[7] !== 1'b1) begin n_fail++; $display("FAIL same_busy_kept: got %b expected 1", bus.busy[7]); end
      n_checks++; if (bus.wb_err !== 1'b0) begin n_fail++; $display("FAIL same_err: got %b expected 0", bus.wb_err); end
      tick();
   endtask

   task automatic test_error();
      bus.lsu_valid = 1; bus.lsu_rd = 5'd9; bus.lsu_data = 64'h99;
      #2;
      n_checks++; if (bus.busy[9] !== 1'b0) begin n_fail++; $display("FAIL err_precond: got %b expected 0", bus.busy[9]); end
      n_checks++; if (bus.lsu_ready !== 1'b1) begin n_fail++; $display("FAIL err_lsu_grant: got %b expected 1", bus.lsu_ready); end
      tick();
      bus.lsu_valid = 0;
      #2;
      n_checks++; if ({bus.wb_en, bus.wb_rd, bus.wb_err} !== {1'b1, 5'd9, 1'b0}) begin n_fail++; $display("FAIL err_wb: got en/rd/err %b/%0d/%b expected 1/9/0", bus.wb_en, bus.wb_rd, bus.wb_err); end
      tick();
      for (int i = 0; i < 3; i++) begin
         #2;
         n_checks++; if (bus.wb_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky%0d: got %b expected 1", i, bus.wb_err); end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_issue(1, 5'd0, 5'd0, 5'd5, 1); tick();
      idle_inputs();
      bus.alu_valid = 1; bus.alu_rd = 5'd5; bus.alu_data = 64'hDEAD;
      bus.lsu_valid = 1; bus.lsu_rd = 5'd11; bus.lsu_data = 64'hBEEF;
      #2;
      n_checks++; if (bus.busy !== 32'h20) begin n_fail++; $display("FAIL rmid_busy: got %h expected 00000020", bus.busy); end
      n_checks++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_grant: got %b expected 1", bus.alu_ready); end
      #1 rst = 0;
      #1;
      n_checks++; if (bus.busy !== 32'h0) begin n_fail++; $display("FAIL rmid_busy_clr: got %h expected 0", bus.busy); end
      n_checks++; if ({bus.wb_en, bus.wb_rd, bus.wb_err} !== 7'd0) begin n_fail++; $display("FAIL rmid_wb: got en/rd/err %b/%0d/%b expected 0/0/0", bus.wb_en, bus.wb_rd, bus.wb_err); end
      n_checks++; if (bus.wb_data !== '0) begin n_fail++; $display("FAIL rmid_data: got %h expected 0", bus.wb_data); end
      n_checks++; if (bus.stall_cnt !== 32'd0) begin n_fail++; $display("FAIL rmid_stall: got %0d expected 0", bus.stall_cnt); end
      idle_inputs();
      model_reset();
      @(negedge clk);
      rst = 1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         #2;
         n_checks++; if (bus.wb_en !== 1'b0) begin n_fail++; $display("FAIL rmid_no_pulse%0d: got %b expected 0", i, bus.wb_en); end
         tick();
      end
   endtask

   function automatic logic [4:0] pick_rd();
      int q[$];
      for (int i = 1; i < 32; i++) if (pend[i]) q.push_back(i);
      if (q.size() != 0 && ($urandom % 4) != 0) return 5'(q[$urandom % q.size()]);
      return 5'($urandom);
   endfunction

   task automatic test_random();
      bit ga, gl;
      idle_inputs();
      for (int c = 0; c < 600; c++) begin
         if (!bus.alu_valid && ($urandom % 3) == 0) begin
            bus.alu_valid = 1; bus.alu_rd = pick_rd(); bus.alu_data = {$urandom, $urandom};
         end
         if (!bus.lsu_valid && ($urandom % 3) == 0) begin
            bus.lsu_valid = 1; bus.lsu_rd = pick_rd(); bus.lsu_data = {$urandom, $urandom};
         end
         set_issue(($urandom % 4) != 0, 5'($urandom % 12), 5'($urandom % 12), 5'($urandom), ($urandom % 3) != 0);
         #2;
         ga = exp_alu_gnt();
         gl = exp_lsu_gnt();
         n_checks++; if (bus.iss_ready !== exp_iss_ready()) begin n_fail++; $display("FAIL rnd_iss_ready c%0d: got %b expected %b", c, bus.iss_ready, exp_iss_ready()); end
         n_checks++; if ({bus.alu_ready, bus.lsu_ready} !== {ga, gl}) begin n_fail++; $display("FAIL rnd_grant c%0d: got %b expected %b", c, {bus.alu_ready, bus.lsu_ready}, {ga, gl}); end
         n_checks++; if (bus.wb_en !== m_wb_en) begin n_fail++; $display("FAIL rnd_wb_en c%0d: got %b expected %b", c, bus.wb_en, m_wb_en); end
         n_checks++; if (bus.wb_rd !== m_wb_rd) begin n_fail++; $display("FAIL rnd_wb_rd c%0d: got %0d expected %0d", c, bus.wb_rd, m_wb_rd); end
         n_checks++; if (bus.wb_data !== m_wb_data) begin n_fail++; $display("FAIL rnd_wb_data c%0d: got %h expected %h", c, bus.wb_data, m_wb_data); end
         n_checks++; if (bus.busy !== exp_busy()) begin n_fail++; $display("FAIL rnd_busy c%0d: got %h expected %h", c, bus.busy, exp_busy()); end
         n_checks++; if (bus.stall_cnt !== m_stall) begin n_fail++; $display("FAIL rnd_stall c%0d: got %0d expected %0d", c, bus.stall_cnt, m_stall); end
         n_checks++; if (bus.wb_err !== m_err) begin n_fail++; $display("FAIL rnd_err c%0d: got %b expected %b", c, bus.wb_err, m_err); end
         tick();
         if (ga) bus.alu_valid = 0;
         if (gl) bus.lsu_valid = 0;
      end
      idle_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_raw_stall();
      test_tie();
      test_rd0();
      test_same_edge();
      test_error();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
